// File: rtl/serial_frame_tx_pkg.sv
// Definitions shared by both ends of the one-wire serial link: FSM encodings,
// framing line levels and the frame length.
package serial_frame_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_GUARD  = 3'd2,
        ST_PARITY = 3'd3,
        ST_DATA   = 3'd4,
        ST_STOP   = 3'd5,
        ST_GAP    = 3'd6
    } tx_state_e;

    localparam logic LVL_START = 1'b1;
    localparam logic LVL_GUARD = 1'b1;
    localparam logic LVL_STOP  = 1'b1;
    localparam logic LVL_IDLE  = 1'b0;

    // START + GUARD + PARITY + payload + STOP
    function automatic int frame_len(input int bit_len);
        return bit_len + 4;
    endfunction

endpackage

// File: rtl/tx_hold_buf.sv
// One-entry valid/ready holding register for the next word to be framed.
module tx_hold_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic         full,
    output logic [W-1:0] dout
);

    logic         full_q, full_d;
    logic [W-1:0] data_q, data_d;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (pop) begin
            full_d = 1'b0;
        end
        // A push on the same edge as a pop refills the entry.
        if (push) begin
            full_d = 1'b1;
            data_d = din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign full = full_q;
    assign dout = data_q;

endmodule

// File: rtl/serial_frame_tx.sv
// Parallel-to-serial framer: START, GUARD, even PARITY, payload LSB first,
// STOP, then an idle-low gap, one bit per clock on channel_out.
module serial_frame_tx
    import serial_frame_tx_pkg::*;
#(
    parameter int BIT_LEN  = 7,
    parameter int IDLE_GAP = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [BIT_LEN-1:0] data_in,
    input  logic               valid_in,
    output logic               ready_out,
    input  logic               parity_flip,
    output logic               channel_out,
    output logic               busy
);

    localparam int BCW = $clog2(BIT_LEN + 1);
    localparam int GCW = $clog2(IDLE_GAP + 1);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(BIT_LEN - 1);
    localparam logic [GCW-1:0] GAP_LAST = GCW'(IDLE_GAP - 1);
    localparam logic [BCW-1:0] BIT_ONE  = BCW'(1);
    localparam logic [GCW-1:0] GAP_ONE  = GCW'(1);

    tx_state_e          state_q, state_d;
    logic [BIT_LEN-1:0] shift_q, shift_d;
    logic [BCW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [GCW-1:0]     gap_cnt_q, gap_cnt_d;
    logic               parity_q, parity_d;
    logic               chan_q, chan_d;

    logic               hold_full;
    logic [BIT_LEN:0]   hold_dout;
    logic               hold_push;
    logic               load;

    assign hold_push = valid_in & ~hold_full;

    tx_hold_buf #(
        .W(BIT_LEN + 1)
    ) u_hold (
        .clk  (clk),
        .rst  (rst),
        .push (hold_push),
        .din  ({parity_flip, data_in}),
        .pop  (load),
        .full (hold_full),
        .dout (hold_dout)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        parity_d  = parity_q;
        chan_d    = chan_q;
        load      = 1'b0;

        // chan_d is the level of the state being entered, so the line is a pure flop.
        case (state_q)
            ST_IDLE: begin
                chan_d = LVL_IDLE;
                load   = hold_full;
            end
            ST_START: begin
                state_d = ST_GUARD;
                chan_d  = LVL_GUARD;
            end
            ST_GUARD: begin
                state_d = ST_PARITY;
                chan_d  = parity_q;
            end
            ST_PARITY: begin
                state_d   = ST_DATA;
                bit_cnt_d = '0;
                chan_d    = shift_q[0];
                shift_d   = shift_q >> 1;
            end
            ST_DATA: begin
                if (bit_cnt_q == BIT_LAST) begin
                    state_d = ST_STOP;
                    chan_d  = LVL_STOP;
                end else begin
                    bit_cnt_d = bit_cnt_q + BIT_ONE;
                    chan_d    = shift_q[0];
                    shift_d   = shift_q >> 1;
                end
            end
            ST_STOP: begin
                state_d   = ST_GAP;
                gap_cnt_d = '0;
                chan_d    = LVL_IDLE;
            end
            ST_GAP: begin
                chan_d = LVL_IDLE;
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                    load    = hold_full;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                chan_d  = LVL_IDLE;
            end
        endcase

        // Loading from the hold register starts the next frame on this same edge.
        if (load) begin
            state_d  = ST_START;
            chan_d   = LVL_START;
            shift_d  = hold_dout[BIT_LEN-1:0];
            parity_d = (^hold_dout[BIT_LEN-1:0]) ^ hold_dout[BIT_LEN];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            parity_q  <= 1'b0;
            chan_q    <= LVL_IDLE;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            parity_q  <= parity_d;
            chan_q    <= chan_d;
        end
    end

    assign channel_out = chan_q;
    assign ready_out   = ~hold_full;
    assign busy        = (state_q != ST_IDLE) | hold_full;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Scoreboard bench for serial_frame_tx: a receiver model decodes channel_out
// and compares each frame against the expectation queued by the stimulus.
module tb_serial_frame_tx;

    localparam int BL  = 7;
    localparam int GAP = 2;
    localparam int FL  = BL + 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [BL-1:0] data_in;
    logic          valid_in;
    logic          ready_out;
    logic          parity_flip;
    logic          channel_out;
    logic          busy;

    serial_frame_tx #(
        .BIT_LEN  (BL),
        .IDLE_GAP (GAP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .valid_in    (valid_in),
        .ready_out   (ready_out),
        .parity_flip (parity_flip),
        .channel_out (channel_out),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [FL-1:0] bits;
        logic [BL-1:0] data;
        logic          flip;
        int            gap;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Frame in transmission order, first bit in the MSB.
    function automatic logic [FL-1:0] build_frame(input logic [BL-1:0] d, input logic f);
        logic [FL-1:0] b;
        b[FL-1] = 1'b1;
        b[FL-2] = 1'b1;
        b[FL-3] = (^d) ^ f;
        for (int i = 0; i < BL; i++) b[FL-4-i] = d[i];
        b[0] = 1'b1;
        return b;
    endfunction

    task automatic expect_frame(input logic [FL-1:0] bits, input logic [BL-1:0] d,
                                input logic f, input int gap);
        exp_t e;
        e.bits = bits;
        e.data = d;
        e.flip = f;
        e.gap  = gap;
        exp_q.push_back(e);
    endtask

    // Receiver model / monitor
    int            mon_zeros = 1000;
    int            mon_nb = 0;
    int            mon_gap = 0;
    logic          mon_in_frame = 1'b0;
    logic [FL-1:0] mon_rx = '0;

    task automatic check_frame();
        exp_t          e;
        logic [BL-1:0] d;
        logic          ok;
        for (int i = 0; i < BL; i++) d[i] = mon_rx[FL-4-i];
        ok = mon_rx[FL-1] & mon_rx[FL-2] & mon_rx[0] & (mon_rx[FL-3] == ^d);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: got %b expected no frame", mon_rx);
        end else begin
            e = exp_q.pop_front();
            chk("frame_bits", 32'(mon_rx), 32'(e.bits));
            chk("rx_data", 32'(d), 32'(e.data));
            chk("rx_is_valid", 32'(ok), 32'(!e.flip));
            if (e.gap != 0) chk("gap_len", mon_gap, e.gap);
            else            chk("gap_min", 32'(mon_gap >= GAP), 32'd1);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            mon_in_frame = 1'b0;
            mon_nb       = 0;
            mon_zeros    = 1000;
        end else if (!mon_in_frame) begin
            if (channel_out) begin
                mon_in_frame = 1'b1;
                mon_rx       = '0;
                mon_rx[0]    = 1'b1;
                mon_nb       = 1;
                mon_gap      = mon_zeros;
            end else begin
                mon_zeros++;
            end
        end else begin
            mon_rx = {mon_rx[FL-2:0], channel_out};
            mon_nb++;
            if (mon_nb == FL) begin
                mon_in_frame = 1'b0;
                mon_zeros    = 0;
                check_frame();
            end
        end
    end

    task automatic send(input logic [BL-1:0] d, input logic f);
        int n;
        valid_in    = 1'b1;
        data_in     = d;
        parity_flip = f;
        n = 0;
        while (!ready_out && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == 200) chk("send_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        valid_in = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_reached", 32'(n < 100), 32'd1);
    endtask

    initial begin
        int   n;
        logic hi;
        logic [BL-1:0] rd;
        logic          rf;

        rst = 1'b1; valid_in = 1'b0; data_in = '0; parity_flip = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_channel", 32'(channel_out), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_ready", 32'(ready_out), 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        // Reset in the middle of a frame with a word waiting in the hold register
        send(7'h7F, 1'b0);
        send(7'h2A, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("pre_reset_line_high", 32'(channel_out), 32'd1);
        chk("pre_reset_hold_full", 32'(ready_out), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_channel", 32'(channel_out), 32'd0);
        chk("async_reset_busy", 32'(busy), 32'd0);
        chk("async_reset_ready", 32'(ready_out), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        hi = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (channel_out || busy) hi = 1'b1;
        end
        chk("post_reset_quiet", 32'(hi), 32'd0);

        // Single word 0x55: latency and busy timing
        expect_frame(11'b11010101011, 7'h55, 1'b0, 0);
        send(7'h55, 1'b0);
        chk("accept_line_low", 32'(channel_out), 32'd0);
        chk("accept_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        chk("first_bit_latency", 32'(channel_out), 32'd1);
        repeat (12) @(posedge clk);
        #1;
        chk("second_gap_low", 32'(channel_out), 32'd0);
        chk("busy_in_gap", 32'(busy), 32'd1);
        @(posedge clk); #1;
        chk("busy_drop", 32'(busy), 32'd0);

        // Word 0x01 with and without parity inversion
        expect_frame(11'b11110000001, 7'h01, 1'b0, 0);
        send(7'h01, 1'b0);
        wait_idle();
        expect_frame(11'b11010000001, 7'h01, 1'b1, 0);
        send(7'h01, 1'b1);
        wait_idle();

        // Back-to-back with valid_in held high
        expect_frame(11'b11001001001, 7'h12, 1'b0, 0);
        expect_frame(11'b11111010111, 7'h6B, 1'b0, GAP);
        expect_frame(11'b11000000001, 7'h00, 1'b0, GAP);
        valid_in = 1'b1; data_in = 7'h12; parity_flip = 1'b0;
        @(posedge clk); #1;
        chk("b2b_ready_after_first", 32'(ready_out), 32'd0);
        data_in = 7'h6B;
        @(posedge clk); #1;
        chk("b2b_ready_after_load", 32'(ready_out), 32'd1);
        @(posedge clk); #1;
        chk("b2b_ready_after_second", 32'(ready_out), 32'd0);
        data_in = 7'h00;
        n = 0;
        while (!ready_out && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("b2b_third_stall_cycles", n, 12);
        @(posedge clk); #1;
        valid_in = 1'b0;
        wait_idle();

        // Loopback with random words and random parity inversion
        for (int i = 0; i < 100; i++) begin
            rd = BL'($urandom_range(0, (1 << BL) - 1));
            rf = 1'($urandom_range(0, 1));
            expect_frame(build_frame(rd, rf), rd, rf, 0);
            send(rd, rf);
        end

        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
